alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 A  input  WIDTH  operand A, unsigned.
REQ-005 B  input  WIDTH  operand B, unsigned.
REQ-006 op  input  3  opcode selecting the operation.
REQ-007 in_valid  input  1  high = A, B and op are sampled this edge.
REQ-008 out  output  WIDTH  registered result.
REQ-009 out_valid  output  1  high for exactly the cycle after an accepted in_valid.
REQ-010 carry  output  1  registered carry/borrow/overflow flag.
REQ-011 zero  output  1  registered flag, high when out is all zeros.

Function
REQ-012 Opcode map SHALL be: 0 ADD A+B; 1 SUB A-B; 2 MUL low WIDTH bits of A*B; 3 DIV A/B quotient; 4 AND A&B; 5 OR A|B; 6 XOR A^B; 7 NOT ~A (B ignored).
REQ-013 Latency SHALL be one clock: inputs sampled on edge N when in_valid=1 appear on out/carry/zero with out_valid=1 after edge N.
REQ-014 When in_valid=0 on an edge, out, carry and zero SHALL hold their previous values and out_valid SHALL be 0.
REQ-015 ADD: out = (A+B) mod 2^WIDTH; carry = bit WIDTH of the full sum.
REQ-016 SUB: out = (A-B) mod 2^WIDTH (two's-complement wrap); carry = 1 iff A < B (borrow).
REQ-017 MUL: out = low WIDTH bits of the 2*WIDTH product; carry = 1 iff the upper WIDTH bits are nonzero.
REQ-018 DIV: out = floor(A/B); carry = 0; if B = 0, out SHALL be all ones and carry SHALL be 1 (divide-by-zero indication).
REQ-019 AND, OR, XOR, NOT: bitwise results; carry = 0.
REQ-020 zero SHALL equal 1 iff the registered out is all zeros, computed from the same operation.
REQ-021 The datapath SHALL be fully combinational between the input sampling point and the output register; no multi-cycle operations.
REQ-022 Operand or op changes while in_valid=0 SHALL have no effect on outputs.

Reset
REQ-023 While rst=1 at a rising edge, out, carry and zero SHALL be 0 and out_valid SHALL be 0, regardless of in_valid.
REQ-024 rst SHALL take priority over in_valid in the same cycle; the operation presented with reset asserted is discarded.
REQ-025 The first accepted operation after rst deasserts SHALL produce its result one clock later with no additional delay.

Structure
REQ-026 A shared package alu_pkg SHALL hold the opcode constants (OP_ADD=0 ... OP_NOT=7) and the default WIDTH.
REQ-027 The divider SHALL be a separate combinational sub-module alu_divider (quotient plus divide-by-zero flag); everything else lives in alu.

Verification
REQ-028 A=50, B=10, in_valid=1, op stepped 0..7, one per clock -> out = 60, 40, 244, 5, 2, 58, 56, 205, each one clock later; carry 0 except MUL (carry=1, 500 > 255).
REQ-029 ADD A=200, B=100 -> out=44, carry=1; ADD A=0, B=0 -> out=0, zero=1, carry=0.
REQ-030 SUB A=10, B=50 -> out=216, carry=1; SUB A=7, B=7 -> out=0, zero=1, carry=0.
REQ-031 DIV A=50, B=0 -> out=255, carry=1; DIV A=9, B=10 -> out=0, zero=1.
REQ-032 rst=1 with in_valid=1, op=0, A=1, B=1 -> next cycle out=0, out_valid=0, flags 0; deassert rst -> next ADD result appears after one clock.
REQ-033 in_valid=0 with changing A/B/op for 3 cycles -> out/carry/zero unchanged, out_valid=0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the opcode map.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } op_e;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned divider: quotient plus divide-by-zero flag.
// A zero divisor forces an all-ones quotient.
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic             dbz
);

  always_comb begin
    dbz = (b == '0);
    quo = '1;
    if (!dbz) quo = a / b;
  end

endmodule

// File: rtl/alu.sv
// Single-cycle ALU: combinational datapath feeding a result/flag register.
// Inputs are accepted only on edges with in_valid high.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic               dbz;
  logic [WIDTH-1:0]   res;
  logic               res_c;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .a   (A),
    .b   (B),
    .quo (quo),
    .dbz (dbz)
  );

  // One extra bit on add/sub exposes carry-out and borrow directly.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
      end
      OP_MUL: begin
        res   = prod[WIDTH-1:0];
        res_c = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        res   = quo;
        res_c = dbz;
      end
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_NOT:  res = ~A;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= res;
      carry     <= res_c;
      zero      <= (res == '0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu with an expected-result scoreboard.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B;
  logic [2:0] op;
  logic       in_valid;
  logic [7:0] out;
  logic       out_valid, carry, zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] o;
    logic       c;
    logic       z;
  } exp_t;

  exp_t q[$];
  exp_t last;

  alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .op        (op),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int a, int b, int o);
    exp_t e;
    int   r;
    e.c = 1'b0;
    r   = 0;
    case (o)
      0: begin r = a + b; e.c = (r > 255); end
      1: begin r = a - b + 256; e.c = (a < b); end
      2: begin r = a * b; e.c = (r > 255); end
      3: begin
        if (b == 0) begin r = 255; e.c = 1'b1; end
        else r = a / b;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 255 - a;
    endcase
    e.o = 8'(r % 256);
    e.z = (e.o == 8'd0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(logic v, logic r, int a, int b, int o, string tag);
    exp_t e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = 8'(a);
    B        = 8'(b);
    op       = 3'(o);
    if (r) begin
      last = '{8'd0, 1'b0, 1'b0};
    end else if (v) begin
      e = model(a, b, o);
      q.push_back(e);
      last = e;
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(v && !r));
    if (v && !r) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s.queue got=empty exp=entry", tag);
      end else begin
        e = q.pop_front();
        chk({tag, ".out"},   32'(out),   32'(e.o));
        chk({tag, ".carry"}, 32'(carry), 32'(e.c));
        chk({tag, ".zero"},  32'(zero),  32'(e.z));
      end
    end else begin
      chk({tag, ".out_hold"},   32'(out),   32'(last.o));
      chk({tag, ".carry_hold"}, 32'(carry), 32'(last.c));
      chk({tag, ".zero_hold"},  32'(zero),  32'(last.z));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; op = '0;
    last = '{8'd0, 1'b0, 1'b0};
    step(0, 1, 0, 0, 0, "reset0");
    step(0, 1, 0, 0, 0, "reset1");

    for (int i = 0; i < 8; i++) step(1, 0, 50, 10, i, $sformatf("sweep_op%0d", i));

    step(1, 0, 200, 100, 0, "add_carry");
    step(1, 0, 0,   0,   0, "add_zero");
    step(1, 0, 10,  50,  1, "sub_borrow");
    step(1, 0, 7,   7,   1, "sub_zero");
    step(1, 0, 50,  0,   3, "div_by_zero");
    step(1, 0, 9,   10,  3, "div_zero_q");
    step(1, 0, 255, 255, 2, "mul_max");
    step(1, 0, 16,  15,  2, "mul_fit");
    step(1, 0, 255, 0,   7, "not_zero");

    step(1, 0, 100, 3, 3, "pre_idle");
    step(0, 0, 1,   2, 0, "idle0");
    step(0, 0, 77,  0, 3, "idle1");
    step(0, 0, 200, 9, 7, "idle2");

    step(1, 1, 1, 1, 0, "rst_priority");
    step(1, 0, 1, 1, 0, "post_rst_add");
    step(1, 0, 128, 128, 0, "add_wrap_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
